// File: rtl/reg_divider_unit.sv
// reg_divider_unit: iterative RV32M DIV/DIVU/REM/REMU, restoring radix-2.
// One quotient bit per cycle; done is a registered one-cycle write-back pulse.
module reg_divider_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic            done_q, done_d;

  logic            a_neg, b_neg, ovf;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   shifted, trial;

  always_comb begin
    a_neg = ~op[0] & operand_a[XLEN-1];
    b_neg = ~op[0] & operand_b[XLEN-1];
    a_abs = a_neg ? -operand_a : operand_a;
    b_abs = b_neg ? -operand_b : operand_b;
    ovf   = ~op[0]
          & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
          & (operand_b == '1);
    // remainder stays below the divisor, so XLEN+1 bits cover the shift
    shifted = {rem_q, quo_q[XLEN-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    rd_d     = rd_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          rd_d  = rd_in;
          sa_d  = a_neg;
          sb_d  = b_neg;
          dvs_d = b_abs;
          if (operand_b == '0) begin
            res_d   = op[1] ? operand_a : '1;
            state_d = DONE;
          end else if (ovf) begin
            res_d   = op[1] ? '0 : operand_a;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            cnt_d   = CW'(XLEN);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIXUP;
      end
      FIXUP: begin
        unique case (op_q)
          2'b00:   res_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
          2'b01:   res_d = quo_q;
          2'b10:   res_d = sa_q ? -rem_q : rem_q;
          default: res_d = rem_q;
        endcase
        state_d = DONE;
      end
      DONE: begin
        done_d   = 1'b1;
        result_d = res_q;
        rd_out_d = rd_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      res_q    <= '0;
      rd_q     <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
